// File: rtl/rvm_mem_responder_if.sv
// Purpose : single-port memory request/grant bundle between a core and its memory.
// Latency : n/a (signal bundle only).
// Backpressure: initiator holds mem_req and the request fields until mem_gnt pulses.
//
// Signals (master = initiator, slave = responder):
//   mem_req   master->slave  request valid, held until mem_gnt
//   mem_wen   master->slave  1 = write, 0 = read
//   mem_ben   master->slave  byte-lane enables for writes
//   mem_addr  master->slave  byte address
//   mem_wdata master->slave  write data
//   mem_gnt   slave->master  one-cycle completion pulse
//   mem_rdata slave->master  read data, held until the next grant
//   mem_error slave->master  fault flag, valid in the grant cycle only
interface rvm_mem_responder_if;
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_ben;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_error;

  modport master (
    output mem_req, mem_wen, mem_ben, mem_addr, mem_wdata,
    input  mem_gnt, mem_rdata, mem_error
  );

  modport slave (
    input  mem_req, mem_wen, mem_ben, mem_addr, mem_wdata,
    output mem_gnt, mem_rdata, mem_error
  );
endinterface

// File: rtl/rvm_mem_responder.sv
// Purpose : memory-side responder serving core requests from an internal word SRAM.
// Latency : grant LATENCY cycles after acceptance (plus 0-3 cycles when stalling is enabled).
// Backpressure: one request in flight; new requests are only accepted in IDLE.
//
// Ports:
//   clk     system clock, all state on the rising edge
//   resetn  asynchronous active-low reset
//   mem     slave side of rvm_mem_responder_if (req/wen/ben/addr/wdata in,
//           gnt/rdata/error out)
//
// Build option: define RVM_MEM_RSP_STALL_EN to add LFSR-driven random extra
// wait cycles (0-3) per request; undefined gives a fixed LATENCY.
module rvm_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic                clk,
  input  logic                resetn,
  rvm_mem_responder_if.slave  mem
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  // One past the last byte of the array; 33 bits so a window ending at 4 GiB
  // does not wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_wen;
  logic [3:0]  r_ben;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_gnt;
  logic        r_error;
  logic [31:0] r_rdata;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic [4:0]  w_extra;
  logic [4:0]  w_load;
  logic        w_wen;
  logic [3:0]  w_ben;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic        w_fault;
  logic        w_we;

  assign w_accept = (r_state == IDLE) && mem.mem_req;

`ifdef RVM_MEM_RSP_STALL_EN
  // Fibonacci LFSR, taps 8,6,5,4; steps once per accepted request and the
  // freshly stepped value sets that request's extra wait.
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_nxt;

  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_extra    = {3'b000, w_lfsr_nxt[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`else
  assign w_extra = 5'd0;
`endif

  // Remaining WAIT cycles after acceptance; zero means grant directly.
  assign w_load = 5'(LATENCY - 1) + w_extra;

  assign w_enter_resp = (w_accept && (w_load == 5'd0)) ||
                        ((r_state == WAIT) && (r_cnt == 5'd1));

  // The request being completed: on the direct IDLE->RESP path the latch
  // registers are not loaded yet, so take the live bus fields.
  assign w_wen   = (r_state == IDLE) ? mem.mem_wen   : r_wen;
  assign w_ben   = (r_state == IDLE) ? mem.mem_ben   : r_ben;
  assign w_addr  = (r_state == IDLE) ? mem.mem_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? mem.mem_wdata : r_wdata;

  // Range check on the full address before any truncation to an index.
  assign w_fault = (w_addr[1:0] != 2'b00) ||
                   (w_addr < BASE_ADDR) ||
                   ({1'b0, w_addr} >= LIMIT);

  assign w_off = w_addr - BASE_ADDR;
  assign w_idx = IDX_W'(w_off >> 2);

  // Gated by resetn so a clock edge during reset can never commit a write.
  assign w_we = resetn && w_enter_resp && w_wen && !w_fault;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_ben[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_wen   <= 1'b0;
      r_ben   <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_gnt   <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_gnt   <= 1'b0;
      r_error <= 1'b0;

      case (r_state)
        IDLE: begin
          if (mem.mem_req) begin
            r_wen   <= mem.mem_wen;
            r_ben   <= mem.mem_ben;
            r_addr  <= mem.mem_addr;
            r_wdata <= mem.mem_wdata;
            if (w_load == 5'd0) begin
              r_state <= RESP;
              r_cnt   <= 5'd0;
            end else begin
              r_state <= WAIT;
              r_cnt   <= w_load;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          // Never accept here: a request still high now is the next one and
          // is taken from IDLE on the following edge.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_enter_resp) begin
        r_gnt   <= 1'b1;
        r_error <= w_fault;
        if (!w_wen) begin
          r_rdata <= w_fault ? 32'h0 : r_mem[w_idx];
        end
      end
    end
  end

  assign mem.mem_gnt   = r_gnt;
  assign mem.mem_error = r_error;
  assign mem.mem_rdata = r_rdata;

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Purpose : directed self-checking bench for rvm_mem_responder (default build).
// Latency : expects grant 2 cycles after acceptance with LATENCY=2.
// Backpressure: bench acts as initiator, holding the request until grant.
module tb_rvm_mem_responder;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  rvm_mem_responder_if bus ();

  rvm_mem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .LATENCY     (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .mem    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the grant, then confirm the grant
  // and error flags drop after one cycle.
  task automatic xact(input string tag, input logic wen, input logic [3:0] ben,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output logic [31:0] rd, output logic err);
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_wen   = wen;
    bus.mem_ben   = ben;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    lat = -1;
    rd  = 32'h0;
    err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_gnt === 1'b1) begin
        lat = c;
        rd  = bus.mem_rdata;
        err = bus.mem_error;
        break;
      end
    end
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_gnt_pulse"}, 32'(bus.mem_gnt), 32'h0);
    chk({tag, "_err_pulse"}, 32'(bus.mem_error), 32'h0);
  endtask

  task automatic do_wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] ben, input logic exp_err);
    int lat;
    logic [31:0] rd;
    logic err;
    xact(tag, 1'b1, ben, addr, wdata, lat, rd, err);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic do_rd(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_data, input logic exp_err);
    int lat;
    logic [31:0] rd;
    logic err;
    xact(tag, 1'b0, 4'h0, addr, 32'h0, lat, rd, err);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_data"}, rd, exp_data);
  endtask

  initial begin
    int          gnt_cyc [3];
    logic [31:0] gnt_dat [3];
    int          got;
    int          stray;

    checks        = 0;
    failures      = 0;
    resetn        = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_ben   = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.mem_gnt), 32'h0);
    chk("rst_err", 32'(bus.mem_error), 32'h0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Full-word write then read back
    do_wr("wr10", 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    chk("wr10_rdata_kept", bus.mem_rdata, 32'h0);
    do_rd("rd10", 32'h10, 32'hDEAD_BEEF, 1'b0);

    // Partial-lane write: lanes 0 and 2 only
    do_wr("pre20", 32'h20, 32'h1122_3344, 4'hF, 1'b0);
    do_wr("wr20_ben5", 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0);
    do_rd("rd20_merge", 32'h20, 32'h11BB_33DD, 1'b0);

    // Misaligned read faults, next aligned read is clean
    do_rd("rd22_misal", 32'h22, 32'h0, 1'b1);
    do_rd("rd20_after", 32'h20, 32'h11BB_33DD, 1'b0);

    // Top-of-array boundary
    do_wr("wrffc", 32'h0FFC, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_wr("wr1000_oor", 32'h1000, 32'h5555_AAAA, 4'hF, 1'b1);
    do_rd("rdffc", 32'h0FFC, 32'hCAFE_F00D, 1'b0);
    do_rd("rd1000_oor", 32'h1000, 32'h0, 1'b1);

    // Empty byte-enable write is a clean no-op
    do_wr("wr10_ben0", 32'h10, 32'h0000_0000, 4'h0, 1'b0);
    do_rd("rd10_ben0", 32'h10, 32'hDEAD_BEEF, 1'b0);

    // Back-to-back reads with mem_req held high throughout
    do_wr("wr00", 32'h00, 32'hA0A0_0000, 4'hF, 1'b0);
    do_wr("wr04", 32'h04, 32'hB0B0_0004, 4'hF, 1'b0);
    do_wr("wr08", 32'h08, 32'hC0C0_0008, 4'hF, 1'b0);
    got = 0;
    for (int i = 0; i < 3; i++) begin
      gnt_cyc[i] = -1;
      gnt_dat[i] = 32'h0;
    end
    @(negedge clk);
    bus.mem_req  = 1'b1;
    bus.mem_wen  = 1'b0;
    bus.mem_ben  = 4'h0;
    bus.mem_addr = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_gnt === 1'b1) begin
        gnt_cyc[got] = c;
        gnt_dat[got] = bus.mem_rdata;
        got++;
        if (got == 3) begin
          bus.mem_req = 1'b0;
          break;
        end
        bus.mem_addr = 32'(got * 4);
      end
    end
    bus.mem_req = 1'b0;
    chk("b2b_cyc0", 32'(gnt_cyc[0]), 32'd2);
    chk("b2b_cyc1", 32'(gnt_cyc[1]), 32'd5);
    chk("b2b_cyc2", 32'(gnt_cyc[2]), 32'd8);
    chk("b2b_dat0", gnt_dat[0], 32'hA0A0_0000);
    chk("b2b_dat1", gnt_dat[1], 32'hB0B0_0004);
    chk("b2b_dat2", gnt_dat[2], 32'hC0C0_0008);
    @(posedge clk);
    #1;
    chk("b2b_gnt_end", 32'(bus.mem_gnt), 32'h0);

    // Reset while a write waits: write dropped, no late grant
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_wen   = 1'b1;
    bus.mem_ben   = 4'hF;
    bus.mem_addr  = 32'h10;
    bus.mem_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("rstmid_gnt_wait", 32'(bus.mem_gnt), 32'h0);
    resetn      = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    chk("rstmid_rdata", bus.mem_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    stray  = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_gnt === 1'b1) stray++;
    end
    chk("rstmid_no_gnt", 32'(stray), 32'h0);
    chk("rstmid_rdata_after", bus.mem_rdata, 32'h0);
    do_rd("rstmid_rd10", 32'h10, 32'hDEAD_BEEF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
